// File: rtl/VX_gpu_pkg.sv
// Shared package for the memory-side tag remapper.
// Provides the memory-tag width helper, the performance counter width and
// the performance counter bundle. The bundle is only used when
// VX_MEM_TAG_REMAP_PERF_EN is defined.
package VX_gpu_pkg;

    localparam int PERF_CTR_BITS = 32;

    // Width of a memory-side ID that indexes NUM_IDS entries.
    // The result is never below 1, so a port of this width always exists.
    function automatic int calc_id_width(input int num_ids);
        return (num_ids <= 2) ? 1 : $clog2(num_ids);
    endfunction

    typedef struct packed {
        logic [PERF_CTR_BITS-1:0] reads;
        logic [PERF_CTR_BITS-1:0] full_stalls;
        logic [PERF_CTR_BITS-1:0] latency;
    } mem_remap_perf_t;

endpackage

// File: rtl/vx_mem_id_alloc.sv
// Free-ID pool for the tag remapper.
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   alloc_en               consume the ID shown on alloc_id this cycle
//   alloc_id, any_free     lowest free ID, and whether any ID is free
//   release_en, release_id return an ID to the pool
//   free_mask              registered free mask (bit set = ID is free)
//   pending                number of IDs currently allocated
module vx_mem_id_alloc
    import VX_gpu_pkg::*;
#(
    parameter int NUM_IDS  = 16,
    parameter int ID_WIDTH = calc_id_width(NUM_IDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_en,
    output logic [ID_WIDTH-1:0] alloc_id,
    output logic                any_free,
    input  logic                release_en,
    input  logic [ID_WIDTH-1:0] release_id,
    output logic [NUM_IDS-1:0]  free_mask,
    output logic [ID_WIDTH:0]   pending
);

    logic [NUM_IDS-1:0] free_q, free_d;
    logic [ID_WIDTH:0]  pending_q, pending_d;

    // Allocation looks only at the registered mask, so an ID released
    // this cycle becomes allocatable on the next cycle.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_id = ID_WIDTH'(i);
        end
    end

    assign any_free  = |free_q;
    assign free_mask = free_q;
    assign pending   = pending_q;

    // Alloc and release never target the same ID: alloc picks a free
    // ID, and a legal release names an allocated one.
    always_comb begin
        free_d    = free_q;
        pending_d = pending_q;
        if (alloc_en)   free_d[alloc_id]   = 1'b0;
        if (release_en) free_d[release_id] = 1'b1;
        case ({alloc_en, release_en})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_q    <= '1;
            pending_q <= '0;
        end else begin
            free_q    <= free_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/vx_mem_tag_remap.sv
// Memory-side tag remapper. Each read takes the lowest free small ID, and
// the wide core tag is parked in a table until the response returns.
// Writes pass straight through with tag 0.
// Ports:
//   core_req_*  request from the core (valid/ready)
//   core_rsp_*  restored response, registered (valid/ready)
//   mem_req_*   request to memory, combinational from core_req_*
//   mem_rsp_*   response from memory, tagged with the small ID
//   idle        no reads outstanding and the output register is empty
//   err         sticky: a response arrived for an ID that was not allocated
// Optional feature: define VX_MEM_TAG_REMAP_PERF_EN to add the perf_reads,
// perf_full_stalls and perf_latency counter outputs.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. A valid source keeps its payload stable until the transfer.
// mem_req_valid never depends on mem_req_ready.
module vx_mem_tag_remap
    import VX_gpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 16,
    parameter int NUM_IDS    = 16,
    parameter int ID_WIDTH   = calc_id_width(NUM_IDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req_valid,
    input  logic                    core_req_rw,
    input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_req_ready,
    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    input  logic                    core_rsp_ready,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [ID_WIDTH-1:0]     mem_req_tag,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [ID_WIDTH-1:0]     mem_rsp_tag,
    output logic                    mem_rsp_ready,
    output logic                    idle,
    output logic                    err
`ifdef VX_MEM_TAG_REMAP_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_reads,
    output logic [PERF_CTR_BITS-1:0] perf_full_stalls,
    output logic [PERF_CTR_BITS-1:0] perf_latency
`endif
);

    logic                read_fire;
    logic                rsp_fire;
    logic                rsp_stray;
    logic                rsp_release;
    logic [ID_WIDTH-1:0] alloc_id;
    logic                any_free;
    logic [NUM_IDS-1:0]  free_mask;
    logic [ID_WIDTH:0]   pending;

    logic [TAG_WIDTH-1:0]  tag_table_q [NUM_IDS];
    logic [TAG_WIDTH-1:0]  tag_table_d [NUM_IDS];
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
    logic                  err_q, err_d;

    vx_mem_id_alloc #(
        .NUM_IDS  (NUM_IDS),
        .ID_WIDTH (ID_WIDTH)
    ) u_id_alloc (
        .clk        (clk),
        .reset      (reset),
        .alloc_en   (read_fire),
        .alloc_id   (alloc_id),
        .any_free   (any_free),
        .release_en (rsp_release),
        .release_id (mem_rsp_tag),
        .free_mask  (free_mask),
        .pending    (pending)
    );

    // Request path: writes bypass the ID pool; reads need a free ID.
    assign mem_req_valid  = core_req_valid & (core_req_rw | any_free);
    assign core_req_ready = mem_req_ready & (core_req_rw | any_free);
    assign mem_req_rw     = core_req_rw;
    assign mem_req_byteen = core_req_byteen;
    assign mem_req_addr   = core_req_addr;
    assign mem_req_data   = core_req_data;
    assign mem_req_tag    = core_req_rw ? '0 : alloc_id;
    assign read_fire      = core_req_valid & ~core_req_rw & any_free & mem_req_ready;

    // Response path: a response naming a free ID is dropped and flagged,
    // and it neither releases an ID nor touches the output register.
    assign mem_rsp_ready = ~out_valid_q | core_rsp_ready;
    assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;
    assign rsp_stray     = rsp_fire & free_mask[mem_rsp_tag];
    assign rsp_release   = rsp_fire & ~free_mask[mem_rsp_tag];

    always_comb begin
        tag_table_d = tag_table_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        err_d       = err_q | rsp_stray;
        if (read_fire) tag_table_d[alloc_id] = core_req_tag;
        if (rsp_release) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_rsp_data;
            out_tag_d   = tag_table_q[mem_rsp_tag];
        end else if (core_rsp_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Payload storage is qualified by the valid/free state, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_table_q <= tag_table_d;
        out_data_q  <= out_data_d;
        out_tag_q   <= out_tag_d;
    end

    assign core_rsp_valid = out_valid_q;
    assign core_rsp_data  = out_data_q;
    assign core_rsp_tag   = out_tag_q;
    assign idle           = (pending == '0) & ~out_valid_q;
    assign err            = err_q;

`ifdef VX_MEM_TAG_REMAP_PERF_EN
    mem_remap_perf_t perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (read_fire) perf_d.reads = perf_q.reads + 1'b1;
        if (core_req_valid & ~core_req_rw & ~any_free)
            perf_d.full_stalls = perf_q.full_stalls + 1'b1;
        perf_d.latency = perf_q.latency + PERF_CTR_BITS'(pending);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_reads       = perf_q.reads;
    assign perf_full_stalls = perf_q.full_stalls;
    assign perf_latency     = perf_q.latency;
`endif

endmodule

// File: doc/vx_mem_tag_remap.md
# vx_mem_tag_remap

Memory-side tag remapper between the Vortex top-level memory ports and the external memory controller (one instance per memory port). It replaces the wide core tag of each read request with a small transaction ID from a free pool, stores the original tag, and restores it on the response. This lets memory controllers with narrow ID fields serve the GPU, caps outstanding reads, and reports an idle indication for the system `busy` logic.

## Interface
Parameters:
- `ADDR_WIDTH`, 26: line address width.
- `DATA_WIDTH`, 512: line data width; byteen width is `DATA_WIDTH/8`.
- `TAG_WIDTH`, 16: core-side tag width.
- `NUM_IDS`, 16: outstanding-read capacity; power of 2, ≥2.
- `ID_WIDTH`, `CLOG2(NUM_IDS)`: memory-side tag width (derived).

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `core_req_valid/rw/byteen/addr/data/tag` in: request from the core side.
- `core_req_ready` out 1: request accepted.
- `core_rsp_valid` out 1, `core_rsp_data` out `DATA_WIDTH`, `core_rsp_tag` out `TAG_WIDTH`: restored response.
- `core_rsp_ready` in 1: response consumer ready.
- `mem_req_valid/rw/byteen/addr/data` out, `mem_req_tag` out `ID_WIDTH`: request to memory.
- `mem_req_ready` in 1: memory accepts.
- `mem_rsp_valid` in 1, `mem_rsp_data` in `DATA_WIDTH`, `mem_rsp_tag` in `ID_WIDTH`: memory response.
- `mem_rsp_ready` out 1: response accepted.
- `idle` out 1: no reads outstanding and the output register is empty.
- `err` out 1: sticky flag for a response to an unallocated ID.

## Operation
- Request path is combinational, with no added latency.
- Writes (`rw=1`):
  - Forwarded with `mem_req_tag=0`; no ID is consumed and no response is expected.
  - `core_req_ready = mem_req_ready`.
- Reads (`rw=0`):
  - Allocate the lowest free ID from the free mask (priority encoder). `mem_req_tag` carries that ID.
  - `mem_req_valid = core_req_valid & any_free`.
  - `core_req_ready = mem_req_ready & any_free`.
  - On fire, set `table[id] = core_req_tag`, clear `free[id]`, and increment `pending`.
- Response path:
  - `mem_rsp_ready = ~out_valid | core_rsp_ready`.
  - On fire, load the output register with data and `table[mem_rsp_tag]`, set `free[mem_rsp_tag]`, and decrement `pending`.
- Alloc and release in the same cycle: both take effect. The released ID becomes allocatable only from the next cycle, because allocation uses the registered mask.
- Response with `free[id]=1`: set `err`, drop the response, and leave `pending` unchanged.
- `pending` is `ID_WIDTH+1` bits wide and never exceeds `NUM_IDS`.

## Timing
- Reset (async assert, values held while `reset=1`):
  - `free` all ones, `pending=0`, `out_valid=0`, `err=0`.
  - Outputs: `core_rsp_valid=0`, `idle=1`, `err=0`.
- Release is synchronous to `clk`.
- Reset mid-operation drops all in-flight state. Late memory responses after reset set `err`.
- Response latency: 1 cycle from `mem_rsp` fire to `core_rsp_valid`. Full throughput of one response per cycle while `core_rsp_ready=1`.
- Request latency: 0 cycles. `mem_req_valid` must not depend on `mem_req_ready`.
- When full (`pending==NUM_IDS`), reads stall and writes still pass.

## Configuration
- `VX_MEM_TAG_REMAP_PERF_EN` defined:
  - Adds `PERF_CTR_BITS`-wide outputs `perf_reads` (read fires), `perf_full_stalls` (cycles with `core_req_valid & ~rw & ~any_free`) and `perf_latency` (sum of `pending` each cycle).
  - All three reset to 0.
- Macro not defined: these ports and counters do not exist.

## Structure
- Shared package `VX_gpu_pkg`: `mem_remap_perf_t` struct (reads, full_stalls, latency) and the `ID_WIDTH` derivation helper.
- One sub-module, `vx_mem_id_alloc`: free mask, lowest-free priority encoder, alloc/release ports, `pending` count.
- The tag table and output register live in the top module.

## Test plan
- Reset with the `mem_req` side idle -> `idle=1`, `core_rsp_valid=0`, `err=0`, and the first read gets `mem_req_tag=0`.
- Three reads with tags 0x11, 0x22, 0x33 -> mem tags 0, 1, 2. Respond with IDs 2, 0, 1 -> `core_rsp_tag` 0x33, 0x11, 0x22, each one cycle after the corresponding response fire.
- Issue 16 reads without responses (`NUM_IDS=16`):
  - Read 17 -> `core_req_ready=0`.
  - A write issued in the same cycle passes with tag 0.
  - Responding with ID 5 -> the next read gets ID 5 one cycle later, not in the same cycle.
- Hold `core_rsp_ready=0` while two responses arrive -> the first is held, `mem_rsp_ready=0` for the second, and no data is lost once ready rises.
- Response with ID 7 never allocated -> `err=1` sticky, no `core_rsp_valid`, `pending` unchanged.
- Assert `reset` asynchronously with 4 reads pending -> `idle=1` immediately, and the next read gets ID 0.
